// File: rtl/vga_plot_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_plot_writer: plots (x, y, colour) points into a framebuffer after a  |
// | full background clear. Optional trail erase: VGA_PLOT_ERASE_TRAIL_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_plot_writer #(
  parameter int          H_RES    = 160,
  parameter int          V_RES    = 120,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  input  logic [11:0] in_color,
  output logic        in_ready,
  input  logic        clear_req,
  output logic [14:0] fb_addr,
  output logic [11:0] fb_data,
  output logic        fb_wren,
  output logic        busy,
  output logic        sweep_done
);

  localparam logic [14:0] c_LAST_ADDR = 15'(H_RES * V_RES - 1);

`ifdef VGA_PLOT_ERASE_TRAIL_EN
  typedef enum logic [1:0] {S_CLEAR = 2'd0, S_RUN = 2'd1, S_ERASE = 2'd2} state_t;
`else
  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;
`endif

  state_t      r_state;
  logic [14:0] r_clr_addr;

  // row * H_RES as a sum of shifted copies of row, one per set bit of H_RES
  function automatic logic [14:0] row_base(input logic [6:0] row);
    logic [14:0] acc;
    acc = '0;
    for (int i = 0; i < 15; i++) begin
      if (((H_RES >> i) & 1) == 1) acc = acc + (15'(row) << i);
    end
    return acc;
  endfunction

  logic [6:0]  w_row;
  logic        w_unused_y0;
  logic        w_accept;
  logic        w_in_range;
  logic        w_last_col;
  logic [14:0] w_addr;

  assign w_row       = in_y[7:1];
  assign w_unused_y0 = in_y[0];
  assign w_accept    = in_valid & in_ready;
  assign w_in_range  = ({1'b0, in_x} < 9'(H_RES)) && ({1'b0, w_row} < 8'(V_RES));
  assign w_last_col  = ({1'b0, in_x} == 9'(H_RES - 1));
  assign w_addr      = row_base(w_row) + {7'd0, in_x};

`ifdef VGA_PLOT_ERASE_TRAIL_EN
  localparam int c_COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;

  logic [H_RES-1:0]   r_col_vld;
  logic [6:0]         r_col_row [H_RES];
  logic [14:0]        r_pend_addr;
  logic [11:0]        r_pend_data;
  logic               r_pend_sweep;
  logic [c_COL_W-1:0] w_col;
  logic [14:0]        w_old_addr;

  assign w_col      = in_x[c_COL_W-1:0];
  assign w_old_addr = row_base(r_col_row[w_col]) + {7'd0, in_x};

  always_ff @(posedge clk) begin
    if (!reset && !clear_req && r_state == S_RUN && w_accept && w_in_range)
      r_col_row[w_col] <= w_row;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      fb_wren    <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      sweep_done <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b1;
`ifdef VGA_PLOT_ERASE_TRAIL_EN
      r_col_vld  <= '0;
`endif
    end else if (clear_req && !busy) begin
      // The address-0 write goes out right away; counter resumes at 1
      r_state    <= S_CLEAR;
      r_clr_addr <= 15'd1;
      fb_wren    <= 1'b1;
      fb_addr    <= '0;
      fb_data    <= BG_COLOR;
      sweep_done <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b1;
`ifdef VGA_PLOT_ERASE_TRAIL_EN
      r_col_vld  <= '0;
`endif
    end else begin
      sweep_done <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          fb_wren  <= 1'b1;
          fb_addr  <= r_clr_addr;
          fb_data  <= BG_COLOR;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          if (r_clr_addr == c_LAST_ADDR) begin
            r_state    <= S_RUN;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 15'd1;
          end
        end

        S_RUN: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          fb_wren  <= 1'b0;
          if (w_accept && w_in_range) begin
            fb_wren    <= 1'b1;
            fb_addr    <= w_addr;
            fb_data    <= in_color;
            sweep_done <= w_last_col;
`ifdef VGA_PLOT_ERASE_TRAIL_EN
            r_col_vld[w_col] <= 1'b1;
            // A previously plotted column: blank the old pixel first, park the new one
            if (r_col_vld[w_col]) begin
              r_state      <= S_ERASE;
              fb_addr      <= w_old_addr;
              fb_data      <= BG_COLOR;
              sweep_done   <= 1'b0;
              in_ready     <= 1'b0;
              r_pend_addr  <= w_addr;
              r_pend_data  <= in_color;
              r_pend_sweep <= w_last_col;
            end
`endif
          end
        end

`ifdef VGA_PLOT_ERASE_TRAIL_EN
        S_ERASE: begin
          r_state    <= S_RUN;
          fb_wren    <= 1'b1;
          fb_addr    <= r_pend_addr;
          fb_data    <= r_pend_data;
          sweep_done <= r_pend_sweep;
          in_ready   <= 1'b1;
          busy       <= 1'b0;
        end
`endif

        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_plot_writer: self-checking bench for vga_plot_writer.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vga_plot_writer;

  localparam int          H    = 160;
  localparam int          V    = 120;
  localparam logic [11:0] BG   = 12'h000;
  localparam int          LAST = H * V - 1;
`ifdef VGA_PLOT_ERASE_TRAIL_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic [11:0] in_color = '0;
  logic        clear_req = 1'b0;
  logic        in_ready;
  logic [14:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_wren;
  logic        busy;
  logic        sweep_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_colv [H];
  int          m_colrow [H];
  bit          m_ready;
  bit          m_pend;
  int          m_paddr;
  logic [11:0] m_pdata;
  bit          m_psweep;

  vga_plot_writer #(.H_RES(H), .V_RES(V), .BG_COLOR(BG)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_color(in_color), .in_ready(in_ready), .clear_req(clear_req),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren), .busy(busy),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Full background sweep from 'start' to the last address, then RUN entry
  task automatic check_clear(input int start);
    int bad = 0;
    for (int i = start; i <= LAST; i++) begin
      clear_req = (i == start + 100);
      step();
      if (!(fb_wren === 1'b1 && fb_addr === 15'(i) && fb_data === BG &&
            busy === 1'b1 && in_ready === 1'b0 && sweep_done === 1'b0)) bad++;
    end
    clear_req = 1'b0;
    chk("clear_sweep_bad_cycles", 64'(bad), 64'd0);
    step();
    chk("run_entry_ready_busy_wren", {in_ready, busy, fb_wren}, 3'b100);
    for (int c = 0; c < H; c++) m_colv[c] = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
    logic        e_wren;
    logic [14:0] e_addr;
    logic [11:0] e_data;
    logic        e_sweep;
    logic        chk_ad;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int          k;
    bit          found;
    bit          e_wren, e_ready, e_sweep;
    int          e_addr;
    logic [11:0] e_data;
    int          row;

    tbl[0] = '{1'b1, 8'd10,  8'd40,  12'hFFF, 1'b1, 15'd3210,  12'hFFF, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'd77,  8'd77,  12'h777, 1'b0, 15'd3210,  12'hFFF, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'd200, 8'd0,   12'h123, 1'b0, 15'd0,     12'h000, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'd0,   8'd250, 12'h456, 1'b0, 15'd0,     12'h000, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'd159, 8'd0,   12'h0F0, 1'b1, 15'd159,   12'h0F0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 8'd1,   8'd239, 12'hABC, 1'b1, 15'd19041, 12'hABC, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'd158, 8'd239, 12'h5A5, 1'b1, 15'd19198, 12'h5A5, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'd255, 8'd255, 12'h999, 1'b0, 15'd0,     12'h000, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'd0,   8'd0,   12'h000, 1'b0, 15'd19198, 12'h5A5, 1'b0, 1'b1};

    // Reset state and the initial clear
    repeat (3) step();
    chk("reset_state", {fb_wren, fb_addr, fb_data, sweep_done, in_ready, busy},
        {1'b0, 15'd0, 12'd0, 1'b0, 1'b0, 1'b1});
    reset = 1'b0;
    check_clear(0);

    // Directed point vectors
    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].v; in_x = tbl[i].x; in_y = tbl[i].y; in_color = tbl[i].c;
      step();
      chk($sformatf("vec%0d_wren_sweep_ready", i), {fb_wren, sweep_done, in_ready},
          {tbl[i].e_wren, tbl[i].e_sweep, 1'b1});
      if (tbl[i].chk_ad)
        chk($sformatf("vec%0d_addr_data", i), {fb_addr, fb_data}, {tbl[i].e_addr, tbl[i].e_data});
    end

    // Clear request with a coincident point: point dropped, clear restarts at 0
    in_valid = 1'b1; in_x = 8'd5; in_y = 8'd2; in_color = 12'hF0F; clear_req = 1'b1;
    step();
    in_valid = 1'b0; clear_req = 1'b0;
    chk("clear_req_first_write", {fb_wren, fb_addr, fb_data, busy, in_ready},
        {1'b1, 15'd0, BG, 1'b1, 1'b0});
    check_clear(1);

`ifdef VGA_PLOT_ERASE_TRAIL_EN
    in_valid = 1'b1; in_x = 8'd3; in_y = 8'd20; in_color = 12'hFFF;
    step();
    in_valid = 1'b0;
    chk("trail_first_point", {fb_wren, fb_addr, fb_data, in_ready}, {1'b1, 15'd1603, 12'hFFF, 1'b1});
    step();
    in_valid = 1'b1; in_x = 8'd3; in_y = 8'd60; in_color = 12'hFFF;
    step();
    in_valid = 1'b0;
    chk("trail_erase_write", {fb_wren, fb_addr, fb_data, in_ready}, {1'b1, 15'd1603, BG, 1'b0});
    step();
    chk("trail_new_write", {fb_wren, fb_addr, fb_data, in_ready}, {1'b1, 15'd4803, 12'hFFF, 1'b1});
    m_colv[3] = 1'b1; m_colrow[3] = 30;
`endif

    // Randomized points against the reference model
    m_ready = 1'b1; m_pend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_x     = 8'($urandom_range(0, 175));
      in_y     = 8'($urandom_range(0, 255));
      in_color = 12'($urandom);
      e_wren = 1'b0; e_sweep = 1'b0; e_ready = 1'b1; e_addr = 0; e_data = '0;
      if (m_pend) begin
        e_wren = 1'b1; e_addr = m_paddr; e_data = m_pdata; e_sweep = m_psweep;
        m_pend = 1'b0;
      end else if (in_valid && m_ready && int'(in_x) < H && int'(in_y) / 2 < V) begin
        row = int'(in_y) / 2;
        if (TRAIL && m_colv[in_x]) begin
          e_wren = 1'b1; e_addr = m_colrow[in_x] * H + int'(in_x); e_data = BG; e_ready = 1'b0;
          m_pend = 1'b1; m_paddr = row * H + int'(in_x); m_pdata = in_color;
          m_psweep = (int'(in_x) == H - 1);
        end else begin
          e_wren = 1'b1; e_addr = row * H + int'(in_x); e_data = in_color;
          e_sweep = (int'(in_x) == H - 1);
        end
        m_colv[in_x] = 1'b1; m_colrow[in_x] = row;
      end
      m_ready = e_ready;
      step();
      chk($sformatf("rand%0d", n),
          {fb_wren, in_ready, sweep_done, fb_wren ? fb_addr : 15'd0, fb_wren ? fb_data : 12'd0},
          {e_wren, e_ready, e_sweep, e_wren ? 15'(e_addr) : 15'd0, e_wren ? e_data : 12'd0});
    end
    in_valid = 1'b0;
    step();

    // Reset in the middle of a clear restarts it from address 0
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    k = 0; found = 1'b0;
    while (!found && k < 6000) begin
      if (fb_addr === 15'd5000) found = 1'b1;
      else begin step(); k++; end
    end
    chk("reach_clear_addr_5000", 64'(found), 64'd1);
    reset = 1'b1;
    step();
    chk("mid_clear_reset_state", {fb_wren, fb_addr, in_ready, busy}, {1'b0, 15'd0, 1'b0, 1'b1});
    reset = 1'b0;
    check_clear(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
